dcmac_0_axis_pkt_mon: RTL and testbench

DCMAC_0_AXIS_PKT_MON -- requirements
Module: dcmac_0_axis_pkt_mon

---
 rtl/dcmac_0_axis_pkt_pkg.sv | 55 +++++
 rtl/dcmac_0_axis_pkt_mon_scan.sv | 74 +++++++
 rtl/dcmac_0_axis_pkt_mon.sv | 113 +++++++++++
 tb/tb_dcmac_0_axis_pkt_mon.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcmac_0_axis_pkt_pkg.sv
// Shared LBUS beat format, per-ID monitor context and
// saturating helpers for the DCMAC AXIS packet monitor/generator.
package dcmac_0_axis_pkt_pkg;

   localparam int NUM_ID    = 6;
   localparam int NUM_SEG   = 12;
   localparam int SEG_BYTES = 16;

   typedef struct packed {
      logic [2:0]                id;
      logic [NUM_SEG-1:0]        ena, sop, eop, err;
      logic [NUM_SEG-1:0][3:0]   mty;
      logic [NUM_SEG-1:0][127:0] dat;
   } lbus_pkt_t;

   typedef enum logic {ST_IDLE, ST_IN_PKT} id_state_e;

   // synced=0 only after reset: tails of packets cut by reset drop quietly
   typedef struct packed {
      id_state_e   st;
      logic        synced;
      logic        seeded;
      logic [7:0]  exp;
      logic [15:0] len;
   } id_ctx_t;

   typedef struct packed {
      logic [7:0] bytes;
      logic [3:0] pkts;
      logic [3:0] proto;
      logic [3:0] len_err;
      logic [3:0] err_pkt;
      logic       data_err;
   } scan_res_t;

   localparam id_ctx_t CTX_RST = '{st: ST_IDLE, synced: 1'b0,
      seeded: 1'b0, exp: 8'd0, len: 16'd0};
   localparam id_ctx_t CTX_CLR = '{st: ST_IDLE, synced: 1'b1,
      seeded: 1'b0, exp: 8'd0, len: 16'd0};

   function automatic logic [31:0] sat32(input logic [31:0] v,
                                         input logic [3:0]  inc);
      logic [32:0] s;
      s = {1'b0, v} + {29'd0, inc};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [15:0] sat16(input logic [15:0] v,
                                         input logic [4:0]  inc);
      logic [16:0] s;
      s = {1'b0, v} + {12'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/dcmac_0_axis_pkt_mon_scan.sv
// Combinational walk of one beat's 12 segments against a single
// ID context: packet state, length, byte sum and error tallies.
module dcmac_0_axis_pkt_mon_scan
   import dcmac_0_axis_pkt_pkg::*;
#(
   parameter bit COUNTER_MODE = 1'b0
) (
   input  lbus_pkt_t   pkt_i,
   input  id_ctx_t     ctx_i,
   input  logic [15:0] min_len_i,
   input  logic [15:0] max_len_i,
   output id_ctx_t     ctx_o,
   output scan_res_t   res_o
);

   id_ctx_t   c;
   scan_res_t r;
   logic [4:0] nb;
   logic [7:0] b;
   logic       take;
   logic       bad;

   always_comb begin
      c    = ctx_i;
      r    = '0;
      nb   = '0;
      b    = '0;
      take = 1'b0;
      bad  = 1'b0;
      for (int s = 0; s < NUM_SEG; s++) begin
         if (pkt_i.ena[s]) begin
            nb = pkt_i.eop[s] ? 5'd16 - {1'b0, pkt_i.mty[s]} : 5'd16;
            take = 1'b0;
            if (pkt_i.sop[s]) begin
               if (c.st == ST_IN_PKT) r.proto = r.proto + 4'd1;
               c.st     = ST_IN_PKT;
               c.synced = 1'b1;
               c.len    = '0;
               take     = 1'b1;
            end else if (c.st == ST_IN_PKT) begin
               take = 1'b1;
            end else if (c.synced) begin
               r.proto = r.proto + 4'd1;
            end
            if (take) begin
               r.bytes = r.bytes + {3'd0, nb};
               c.len   = sat16(c.len, nb);
               if (COUNTER_MODE) begin
                  // bytes run MSB-first within a segment
                  for (int k = 0; k < SEG_BYTES; k++) begin
                     if (5'(k) < nb) begin
                        b = pkt_i.dat[s][8*(15-k) +: 8];
                        if (c.seeded && b != c.exp) bad = 1'b1;
                        c.exp    = b + 8'd1;
                        c.seeded = 1'b1;
                     end
                  end
               end
               if (pkt_i.eop[s]) begin
                  r.pkts = r.pkts + 4'd1;
                  if (c.len < min_len_i || c.len > max_len_i)
                     r.len_err = r.len_err + 4'd1;
                  if (pkt_i.err[s]) r.err_pkt = r.err_pkt + 4'd1;
                  c.st = ST_IDLE;
               end
            end
         end
      end
      r.data_err = bad;
      ctx_o = c;
      res_o = r;
   end

endmodule

// File: rtl/dcmac_0_axis_pkt_mon.sv
// Per-ID LBUS packet monitor: input register stage, then a single
// shared segment scan on the beat's ID context and counter update.
module dcmac_0_axis_pkt_mon
   import dcmac_0_axis_pkt_pkg::*;
#(
   parameter bit COUNTER_MODE = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  lbus_pkt_t               i_pkt,
   input  logic                    i_pkt_vld,
   input  logic [15:0]             i_min_len,
   input  logic [15:0]             i_max_len,
   input  logic [NUM_ID-1:0]       i_clear_counters,
   output logic [NUM_ID-1:0][63:0] o_byte_cnt,
   output logic [NUM_ID-1:0][63:0] o_pkt_cnt,
   output logic [NUM_ID-1:0][31:0] o_proto_err_cnt,
   output logic [NUM_ID-1:0][31:0] o_len_err_cnt,
   output logic [NUM_ID-1:0][31:0] o_data_err_cnt,
   output logic [NUM_ID-1:0][31:0] o_err_pkt_cnt,
   output logic [31:0]             o_bad_id_cnt
);

   lbus_pkt_t         pkt_q;
   logic              vld_q;
   logic [NUM_ID-1:0] clr_q;
   logic [15:0]       min_q, max_q;

   id_ctx_t ctx_q [NUM_ID];
   id_ctx_t ctx_sel, ctx_nxt;
   scan_res_t res;
   logic [NUM_ID-1:0] hit;

   logic [NUM_ID-1:0][63:0] byte_q, pkt_cnt_q;
   logic [NUM_ID-1:0][31:0] proto_q, len_q, data_q, errp_q;
   logic [31:0]             bad_q;

   // a clear seen while the beat was registered also cancels it
   always_comb begin
      ctx_sel = CTX_RST;
      hit     = '0;
      for (int k = 0; k < NUM_ID; k++) begin
         if (pkt_q.id == 3'(k)) begin
            ctx_sel = ctx_q[k];
            hit[k]  = vld_q && !clr_q[k];
         end
      end
   end

   dcmac_0_axis_pkt_mon_scan #(
      .COUNTER_MODE(COUNTER_MODE)
   ) u_scan (
      .pkt_i     (pkt_q),
      .ctx_i     (ctx_sel),
      .min_len_i (min_q),
      .max_len_i (max_q),
      .ctx_o     (ctx_nxt),
      .res_o     (res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q     <= '0;
         vld_q     <= 1'b0;
         clr_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         byte_q    <= '0;
         pkt_cnt_q <= '0;
         proto_q   <= '0;
         len_q     <= '0;
         data_q    <= '0;
         errp_q    <= '0;
         bad_q     <= '0;
         for (int k = 0; k < NUM_ID; k++) ctx_q[k] <= CTX_RST;
      end else begin
         pkt_q <= i_pkt;
         vld_q <= i_pkt_vld;
         clr_q <= i_clear_counters;
         min_q <= i_min_len;
         max_q <= i_max_len;
         if (vld_q && pkt_q.id > 3'd5) bad_q <= sat32(bad_q, 4'd1);
         for (int k = 0; k < NUM_ID; k++) begin
            if (i_clear_counters[k]) begin
               byte_q[k]    <= '0;
               pkt_cnt_q[k] <= '0;
               proto_q[k]   <= '0;
               len_q[k]     <= '0;
               data_q[k]    <= '0;
               errp_q[k]    <= '0;
               ctx_q[k]     <= CTX_CLR;
            end else if (hit[k]) begin
               byte_q[k]    <= byte_q[k] + {56'd0, res.bytes};
               pkt_cnt_q[k] <= pkt_cnt_q[k] + {60'd0, res.pkts};
               proto_q[k]   <= sat32(proto_q[k], res.proto);
               len_q[k]     <= sat32(len_q[k], res.len_err);
               data_q[k]    <= sat32(data_q[k], {3'd0, res.data_err});
               errp_q[k]    <= sat32(errp_q[k], res.err_pkt);
               ctx_q[k]     <= ctx_nxt;
            end
         end
      end
   end

   assign o_byte_cnt      = byte_q;
   assign o_pkt_cnt       = pkt_cnt_q;
   assign o_proto_err_cnt = proto_q;
   assign o_len_err_cnt   = len_q;
   assign o_data_err_cnt  = data_q;
   assign o_err_pkt_cnt   = errp_q;
   assign o_bad_id_cnt    = bad_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon.sv
// Bench for dcmac_0_axis_pkt_mon: directed packet scenarios plus
// random beats, checked every cycle against a packet-level model.
module tb_dcmac_0_axis_pkt_mon;
   import dcmac_0_axis_pkt_pkg::*;

   logic clk = 1'b0;
   logic rst;
   lbus_pkt_t i_pkt;
   logic i_pkt_vld;
   logic [15:0] i_min_len, i_max_len;
   logic [5:0] i_clear_counters;
   logic [5:0][63:0] o_byte_cnt, o_pkt_cnt;
   logic [5:0][31:0] o_proto_err_cnt, o_len_err_cnt;
   logic [5:0][31:0] o_data_err_cnt, o_err_pkt_cnt;
   logic [31:0] o_bad_id_cnt;

   dcmac_0_axis_pkt_mon #(.COUNTER_MODE(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_pkt            (i_pkt),
      .i_pkt_vld        (i_pkt_vld),
      .i_min_len        (i_min_len),
      .i_max_len        (i_max_len),
      .i_clear_counters (i_clear_counters),
      .o_byte_cnt       (o_byte_cnt),
      .o_pkt_cnt        (o_pkt_cnt),
      .o_proto_err_cnt  (o_proto_err_cnt),
      .o_len_err_cnt    (o_len_err_cnt),
      .o_data_err_cnt   (o_data_err_cnt),
      .o_err_pkt_cnt    (o_err_pkt_cnt),
      .o_bad_id_cnt     (o_bad_id_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   bit [63:0] m_byte [6];
   bit [63:0] m_pkt [6];
   bit [31:0] m_proto [6], m_len_err [6], m_data [6], m_errp [6];
   bit [31:0] m_bad;
   bit m_open [6], m_heard [6], m_seed [6];
   int m_len [6];
   bit [7:0] m_exp [6];

   lbus_pkt_t cur_pkt, prev_pkt, p, q;
   bit cur_vld, prev_vld, cur_rst;
   bit [5:0] cur_clr, prev_clr;
   int cur_min, cur_max, prev_min, prev_max;
   int min_v = 1, max_v = 1500;
   bit [7:0] gen_next [8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic bit [31:0] inc32(input bit [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic void m_reset_id(input int k, input bit heard);
      m_byte[k] = 0; m_pkt[k] = 0; m_proto[k] = 0;
      m_len_err[k] = 0; m_data[k] = 0; m_errp[k] = 0;
      m_open[k] = 0; m_heard[k] = heard; m_seed[k] = 0;
      m_len[k] = 0; m_exp[k] = 0;
   endfunction

   // packet-level rules applied to one accepted beat
   function automatic void m_beat(input lbus_pkt_t b, input int mn,
                                  input int mx);
      int id, n;
      bit keep, derr;
      bit [7:0] v;
      id = int'(b.id);
      derr = 0;
      for (int s = 0; s < 12; s++) begin
         if (!b.ena[s]) continue;
         n = b.eop[s] ? 16 - int'(b.mty[s]) : 16;
         keep = 0;
         if (b.sop[s]) begin
            if (m_open[id]) m_proto[id] = inc32(m_proto[id]);
            m_open[id] = 1; m_heard[id] = 1; m_len[id] = 0; keep = 1;
         end else if (m_open[id]) begin
            keep = 1;
         end else if (m_heard[id]) begin
            m_proto[id] = inc32(m_proto[id]);
         end
         if (!keep) continue;
         m_byte[id] += 64'(n);
         m_len[id] = (m_len[id] + n > 65535) ? 65535 : m_len[id] + n;
         for (int k = 0; k < n; k++) begin
            v = b.dat[s][8*(15-k) +: 8];
            if (m_seed[id] && v != m_exp[id]) derr = 1;
            m_exp[id] = v + 8'd1;
            m_seed[id] = 1;
         end
         if (b.eop[s]) begin
            m_pkt[id] += 64'd1;
            if (m_len[id] < mn || m_len[id] > mx)
               m_len_err[id] = inc32(m_len_err[id]);
            if (b.err[s]) m_errp[id] = inc32(m_errp[id]);
            m_open[id] = 0;
         end
      end
      if (derr) m_data[id] = inc32(m_data[id]);
   endfunction

   // what one rising edge does: cur = inputs sampled, prev = staged beat
   function automatic void model_edge();
      int id;
      if (cur_rst) begin
         for (int k = 0; k < 6; k++) m_reset_id(k, 1'b0);
         m_bad = 0;
         prev_vld = 0;
         prev_clr = 0;
         return;
      end
      if (prev_vld) begin
         id = int'(prev_pkt.id);
         if (id > 5) m_bad = inc32(m_bad);
         else if (!prev_clr[id] && !cur_clr[id])
            m_beat(prev_pkt, prev_min, prev_max);
      end
      for (int k = 0; k < 6; k++)
         if (cur_clr[k]) m_reset_id(k, 1'b1);
      prev_pkt = cur_pkt; prev_vld = cur_vld; prev_clr = cur_clr;
      prev_min = cur_min; prev_max = cur_max;
   endfunction

   task automatic cyc(input lbus_pkt_t b, input bit v,
                      input bit [5:0] c, input bit r);
      i_pkt = b; i_pkt_vld = v; i_clear_counters = c; rst = r;
      i_min_len = 16'(min_v); i_max_len = 16'(max_v);
      cur_pkt = b; cur_vld = v; cur_clr = c; cur_rst = r;
      cur_min = min_v; cur_max = max_v;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, 1'b0, 6'd0, 1'b0);
   endtask

   function automatic void fill_seg(inout lbus_pkt_t b, input int s,
                                    input int id, input int nb,
                                    input bit corrupt);
      b.ena[s] = 1'b1;
      for (int k = 0; k < nb; k++) begin
         b.dat[s][8*(15-k) +: 8] =
            (corrupt && k == 0) ? gen_next[id] ^ 8'hA5 : gen_next[id];
         gen_next[id] = gen_next[id] + 8'd1;
      end
   endfunction

   task automatic send_pkt(input int id, input int len);
      lbus_pkt_t b;
      int rem, s, nb;
      bit first;
      b = '0; b.id = 3'(id); rem = len; s = 0; first = 1;
      while (rem > 0) begin
         nb = (rem >= 16) ? 16 : rem;
         fill_seg(b, s, id, nb, 1'b0);
         if (first) b.sop[s] = 1'b1;
         first = 0;
         rem -= nb;
         if (rem == 0) begin
            b.eop[s] = 1'b1;
            b.mty[s] = 4'(16 - nb);
         end
         s++;
         if (s == 12 || rem == 0) begin
            cyc(b, 1'b1, 6'd0, 1'b0);
            b = '0; b.id = 3'(id); s = 0;
         end
      end
   endtask

   function automatic lbus_pkt_t rand_beat();
      lbus_pkt_t b;
      int id, nb;
      b = '0;
      id = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7))
                                        : int'($urandom_range(0, 5));
      b.id = 3'(id);
      for (int s = 0; s < 12; s++) begin
         if ($urandom_range(0, 4) == 0) continue;
         b.sop[s] = ($urandom_range(0, 5) == 0);
         b.eop[s] = ($urandom_range(0, 3) == 0);
         b.err[s] = ($urandom_range(0, 7) == 0);
         b.mty[s] = 4'($urandom_range(0, 15));
         nb = b.eop[s] ? 16 - int'(b.mty[s]) : 16;
         fill_seg(b, s, id, nb, $urandom_range(0, 99) == 0);
      end
      return b;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("byte_cnt[%0d]", k), o_byte_cnt[k], m_byte[k]);
            chk($sformatf("pkt_cnt[%0d]", k), o_pkt_cnt[k], m_pkt[k]);
            chk($sformatf("proto_err[%0d]", k),
                64'(o_proto_err_cnt[k]), 64'(m_proto[k]));
            chk($sformatf("len_err[%0d]", k),
                64'(o_len_err_cnt[k]), 64'(m_len_err[k]));
            chk($sformatf("data_err[%0d]", k),
                64'(o_data_err_cnt[k]), 64'(m_data[k]));
            chk($sformatf("err_pkt[%0d]", k),
                64'(o_err_pkt_cnt[k]), 64'(m_errp[k]));
         end
         chk("bad_id_cnt", 64'(o_bad_id_cnt), 64'(m_bad));
      end
   end

   initial begin
      for (int k = 0; k < 8; k++) gen_next[k] = 8'd0;
      cyc('0, 1'b0, 6'd0, 1'b1);
      cyc('0, 1'b0, 6'd0, 1'b1);
      chk_on = 1'b1;
      idle(1);
      @(negedge clk);
      chk("rst_pkt_cnt0", o_pkt_cnt[0], 64'd0);
      chk("rst_bad_id", 64'(o_bad_id_cnt), 64'd0);

      // ID 2: sop seg0, eop seg3 mty 4 -> 60 bytes, visible at N+2
      min_v = 1; max_v = 1500;
      send_pkt(2, 60);
      @(negedge clk);
      chk("lat_n1_byte2", o_byte_cnt[2], 64'd0);
      idle(1);
      @(negedge clk);
      chk("lat_n2_byte2", o_byte_cnt[2], 64'd60);
      chk("lat_n2_pkt2", o_pkt_cnt[2], 64'd1);
      chk("s1_proto2", 64'(o_proto_err_cnt[2]), 64'd0);
      chk("s1_data2", 64'(o_data_err_cnt[2]), 64'd0);

      // ID 0: sop seg0 and seg5, eop seg8
      p = '0; p.id = 3'd0;
      for (int s = 0; s < 9; s++) fill_seg(p, s, 0, 16, 1'b0);
      p.sop[0] = 1'b1; p.sop[5] = 1'b1; p.eop[8] = 1'b1;
      cyc(p, 1'b1, 6'd0, 1'b0);
      idle(2);
      chk("s2_proto0", 64'(o_proto_err_cnt[0]), 64'd1);
      chk("s2_pkt0", o_pkt_cnt[0], 64'd1);
      chk("s2_byte0", o_byte_cnt[0], 64'd144);

      // ID 1: length bounds 64..1500
      min_v = 64; max_v = 1500;
      send_pkt(1, 60);
      send_pkt(1, 1500);
      idle(2);
      chk("s3_len_err1", 64'(o_len_err_cnt[1]), 64'd1);
      chk("s3_pkt1", o_pkt_cnt[1], 64'd2);
      chk("s3_byte1", o_byte_cnt[1], 64'd1560);

      // ID 3: bytes 0x00..0x2F then a corrupted 0x55
      min_v = 1;
      gen_next[3] = 8'd0;
      p = '0; p.id = 3'd3;
      for (int s = 0; s < 3; s++) fill_seg(p, s, 3, 16, 1'b0);
      p.sop[0] = 1'b1;
      p.ena[3] = 1'b1; p.eop[3] = 1'b1; p.mty[3] = 4'd15;
      p.dat[3][127:120] = 8'h55;
      cyc(p, 1'b1, 6'd0, 1'b0);
      idle(2);
      chk("s4_data3", 64'(o_data_err_cnt[3]), 64'd1);
      chk("s4_byte3", o_byte_cnt[3], 64'd49);

      // bad id beat, then ID 4 eop arriving with its clear
      p = '0; p.id = 3'd4;
      fill_seg(p, 0, 4, 16, 1'b0);
      p.sop[0] = 1'b1;
      cyc(p, 1'b1, 6'd0, 1'b0);
      q = '0; q.id = 3'd7;
      q.ena[0] = 1'b1; q.sop[0] = 1'b1; q.eop[0] = 1'b1;
      cyc(q, 1'b1, 6'd0, 1'b0);
      @(negedge clk);
      chk("s5_byte4_pre", o_byte_cnt[4], 64'd16);
      p = '0; p.id = 3'd4;
      fill_seg(p, 0, 4, 16, 1'b0);
      p.eop[0] = 1'b1;
      cyc(p, 1'b1, 6'b010000, 1'b0);
      idle(2);
      chk("s5_bad_id", 64'(o_bad_id_cnt), 64'd1);
      chk("s5_pkt4", o_pkt_cnt[4], 64'd0);
      chk("s5_byte4", o_byte_cnt[4], 64'd0);
      chk("s5_pkt2_kept", o_pkt_cnt[2], 64'd1);

      // reset in the middle of an ID 5 packet
      p = '0; p.id = 3'd5;
      fill_seg(p, 0, 5, 16, 1'b0);
      fill_seg(p, 1, 5, 16, 1'b0);
      p.sop[0] = 1'b1;
      cyc(p, 1'b1, 6'd0, 1'b0);
      cyc('0, 1'b0, 6'd0, 1'b1);
      p = '0; p.id = 3'd5;
      fill_seg(p, 0, 5, 16, 1'b0);
      p.eop[0] = 1'b1;
      cyc(p, 1'b1, 6'd0, 1'b0);
      idle(2);
      chk("s6_proto5", 64'(o_proto_err_cnt[5]), 64'd0);
      chk("s6_pkt5", o_pkt_cnt[5], 64'd0);
      chk("s6_byte0", o_byte_cnt[0], 64'd0);
      chk("s6_bad_id", 64'(o_bad_id_cnt), 64'd0);

      // random traffic
      min_v = 40; max_v = 400;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            min_v = int'($urandom_range(0, 200));
            max_v = int'($urandom_range(100, 2000));
         end
         cyc(rand_beat(), $urandom_range(0, 9) != 0,
             ($urandom_range(0, 39) == 0) ?
                6'(1 << $urandom_range(0, 5)) : 6'd0,
             $urandom_range(0, 499) == 0);
      end
      idle(3);
      @(negedge clk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
